// File: rtl/sprite_draw_ctrl.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite memory in raster order and emits
// clipped, colour-keyed pixel writes for a VGA adapter at the latched position.
module sprite_draw_ctrl #(
   parameter int         SPR_W  = 20,
   parameter int         SPR_H  = 40,
   parameter logic [2:0] TRANSP = 3'b000,
   parameter int         SCR_W  = 160,
   parameter int         SCR_H  = 120
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] x_in,
   input  logic [6:0] y_in,
   output logic [9:0] mem_addr,
   input  logic [2:0] mem_data,
   output logic       plot,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [7:0] COL_LAST = 8'(SPR_W - 1);
   localparam logic [6:0] ROW_LAST = 7'(SPR_H - 1);
   localparam logic [9:0] SPR_W_A  = 10'(SPR_W);
   localparam logic [8:0] SCR_W_X  = 9'(SCR_W);
   localparam logic [7:0] SCR_H_Y  = 8'(SCR_H);

   logic [1:0] state_q, state_d;
   logic [7:0] col_q, col_d;
   logic [6:0] row_q, row_d;
   logic [7:0] x_lat_q, x_lat_d;
   logic [6:0] y_lat_q, y_lat_d;
   logic       stage_valid_q, stage_valid_d;
   logic [7:0] stage_col_q, stage_col_d;
   logic [6:0] stage_row_q, stage_row_d;

   logic [8:0] x_sum_s;
   logic [7:0] y_sum_s;

   // Next-state, raster walk and one-cycle stage aligning (col,row) with mem_data.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      x_lat_d = x_lat_q;
      y_lat_d = y_lat_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               x_lat_d = x_in;
               y_lat_d = y_in;
               col_d   = 8'd0;
               row_d   = 7'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (col_q == COL_LAST) begin
               col_d = 8'd0;
               if (row_q == ROW_LAST) begin
                  state_d = ST_DRAIN;
               end else begin
                  row_d = row_q + 7'd1;
               end
            end else begin
               col_d = col_q + 8'd1;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (state_q == ST_RUN) begin
         stage_valid_d = 1'b1;
         stage_col_d   = col_q;
         stage_row_d   = row_q;
      end else begin
         stage_valid_d = 1'b0;
         stage_col_d   = 8'd0;
         stage_row_d   = 7'd0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         col_q         <= 8'd0;
         row_q         <= 7'd0;
         x_lat_q       <= 8'd0;
         y_lat_q       <= 7'd0;
         stage_valid_q <= 1'b0;
         stage_col_q   <= 8'd0;
         stage_row_q   <= 7'd0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         x_lat_q       <= x_lat_d;
         y_lat_q       <= y_lat_d;
         stage_valid_q <= stage_valid_d;
         stage_col_q   <= stage_col_d;
         stage_row_q   <= stage_row_d;
      end
   end

   // Clipping uses the full-width sums so wrapped coordinates never reach the screen.
   always_comb begin
      x_sum_s = {1'b0, x_lat_q} + {1'b0, stage_col_q};
      y_sum_s = {1'b0, y_lat_q} + {1'b0, stage_row_q};
      if (state_q == ST_RUN) begin
         mem_addr = ({3'b000, row_q} * SPR_W_A) + {2'b00, col_q};
      end else begin
         mem_addr = 10'd0;
      end
      if (stage_valid_q) begin
         x_out  = x_sum_s[7:0];
         y_out  = y_sum_s[6:0];
         colour = mem_data;
         plot   = (mem_data != TRANSP) && (x_sum_s < SCR_W_X) && (y_sum_s < SCR_H_Y);
      end else begin
         x_out  = 8'd0;
         y_out  = 7'd0;
         colour = 3'b000;
         plot   = 1'b0;
      end
      busy = (state_q != ST_IDLE);
      done = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Directed bench for sprite_draw_ctrl: a synchronous-read sprite memory model
// and a cycle-indexed reference of every output across one draw sequence.
module tb_sprite_draw_ctrl;

   logic       clk;
   logic       resetn;
   logic       start;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [9:0] mem_addr;
   logic [2:0] mem_data;
   logic       plot;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       busy;
   logic       done;

   logic [2:0]  mem [0:1023];
   logic [30:0] obs;
   int          checks = 0;
   int          errors = 0;

   sprite_draw_ctrl dut (
      .clk      (clk),
      .resetn   (resetn),
      .start    (start),
      .x_in     (x_in),
      .y_in     (y_in),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .plot     (plot),
      .x_out    (x_out),
      .y_out    (y_out),
      .colour   (colour),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) mem_data <= mem[mem_addr];

   assign obs = {plot, x_out, y_out, colour, busy, done, mem_addr};

   // Expected {plot,x,y,colour,busy,done,addr} in cycle c after a start ending cycle 0.
   function automatic logic [30:0] model(input int c, input int xl, input int yl);
      logic       p;
      logic [7:0] xo;
      logic [6:0] yo;
      logic [2:0] col;
      logic       b;
      logic       d;
      logic [9:0] a;
      int         n;
      int         xs;
      int         ys;
      p = 1'b0; xo = 8'd0; yo = 7'd0; col = 3'b000; a = 10'd0;
      b = (c >= 1) && (c <= 802);
      d = (c == 802);
      if (c >= 1 && c <= 800) a = 10'(c - 1);
      if (c >= 2 && c <= 801) begin
         n   = c - 2;
         xs  = xl + (n % 20);
         ys  = yl + (n / 20);
         xo  = 8'(xs);
         yo  = 7'(ys);
         col = mem[n];
         p   = (col != 3'b000) && (xs < 160) && (ys < 120);
      end
      return {p, xo, yo, col, b, d, a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [2:0] v);
      for (int i = 0; i < 1024; i++) mem[i] = v;
   endtask

   // Presents start for one edge; returns in cycle 1.
   task automatic start_draw(input int xl, input int yl);
      x_in  = 8'(xl);
      y_in  = 7'(yl);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      start  = 1'b1;
      x_in   = 8'd55;
      y_in   = 7'd33;
      fill(3'b101);
      repeat (3) tick();
      checks++;
      if (obs !== 31'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", obs, 31'd0);
      end
      start  = 1'b0;
      resetn = 1'b1;
      tick();
      checks++;
      if (obs !== 31'd0) begin
         errors++;
         $display("FAIL idle_outputs: got %h expected %h", obs, 31'd0);
      end
   endtask

   task automatic test_full_draw();
      int plots = 0;
      logic [30:0] e;
      fill(3'b101);
      start_draw(10, 20);
      for (int c = 1; c <= 803; c++) begin
         e = model(c, 10, 20);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL full_draw cyc %0d: got %h expected %h", c, obs, e);
         end
         if (plot === 1'b1) plots++;
         tick();
      end
      checks++;
      if (plots != 800) begin
         errors++;
         $display("FAIL full_draw_plots: got %0d expected 800", plots);
      end
   endtask

   task automatic test_transparency();
      int plots = 0;
      int bad = 0;
      logic [30:0] e;
      for (int i = 0; i < 1024; i++) mem[i] = (i % 2 == 0) ? 3'b000 : 3'b011;
      start_draw(40, 30);
      for (int c = 1; c <= 803; c++) begin
         e = model(c, 40, 30);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL transparency cyc %0d: got %h expected %h", c, obs, e);
         end
         if (plot === 1'b1) begin
            plots++;
            if (colour !== 3'b011) bad++;
         end
         tick();
      end
      checks++;
      if (plots != 400 || bad != 0) begin
         errors++;
         $display("FAIL transparency_plots: got %0d plots %0d wrong colour expected 400 and 0", plots, bad);
      end
   endtask

   task automatic test_clipping();
      int plots = 0;
      int outside = 0;
      logic [30:0] e;
      fill(3'b101);
      start_draw(150, 100);
      for (int c = 1; c <= 803; c++) begin
         e = model(c, 150, 100);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL clipping cyc %0d: got %h expected %h", c, obs, e);
         end
         if (plot === 1'b1) begin
            plots++;
            if (x_out < 8'd150 || x_out > 8'd159 || y_out < 7'd100 || y_out > 7'd119) outside++;
         end
         tick();
      end
      checks++;
      if (plots != 200 || outside != 0) begin
         errors++;
         $display("FAIL clipping_plots: got %0d plots %0d outside expected 200 and 0", plots, outside);
      end
   endtask

   task automatic test_mapping();
      fill(3'b001);
      mem[21] = 3'b110;
      start_draw(5, 7);
      for (int c = 1; c < 23; c++) tick();
      checks++;
      if ({plot, x_out, y_out, colour} !== {1'b1, 8'd6, 7'd8, 3'b110}) begin
         errors++;
         $display("FAIL mapping_cyc23: got plot %b x %0d y %0d col %b expected 1 6 8 110",
                  plot, x_out, y_out, colour);
      end
      for (int c = 23; c <= 803; c++) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL mapping_idle: got busy %b expected 0", busy);
      end
   endtask

   task automatic test_start_busy();
      logic [30:0] e;
      fill(3'b101);
      start_draw(10, 20);
      for (int c = 1; c <= 803; c++) begin
         e = model(c, 10, 20);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL start_busy cyc %0d: got %h expected %h", c, obs, e);
         end
         if (c == 300) begin
            start = 1'b1;
            x_in  = 8'd77;
            y_in  = 7'd3;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_busy_idle: got busy %b expected 0", busy);
      end
   endtask

   task automatic test_reset_abort();
      int dones = 0;
      logic [30:0] e;
      fill(3'b010);
      start_draw(12, 9);
      for (int c = 1; c <= 400; c++) begin
         e = model(c, 12, 9);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL abort_run cyc %0d: got %h expected %h", c, obs, e);
         end
         if (c < 400) tick();
      end
      resetn = 1'b0;
      tick();
      checks++;
      if (obs !== 31'd0) begin
         errors++;
         $display("FAIL abort_outputs: got %h expected %h", obs, 31'd0);
      end
      resetn = 1'b1;
      for (int c = 0; c < 420; c++) begin
         if (done === 1'b1 || busy === 1'b1) dones++;
         tick();
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d done/busy cycles expected 0", dones);
      end
      start_draw(0, 0);
      for (int c = 1; c <= 803; c++) begin
         e = model(c, 0, 0);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL abort_redraw cyc %0d: got %h expected %h", c, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [30:0] e;
      for (int i = 0; i < 1024; i++) mem[i] = 3'(i % 7 + 1);
      start_draw(30, 40);
      for (int c = 1; c <= 803; c++) begin
         e = model(c, 30, 40);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL b2b_first cyc %0d: got %h expected %h", c, obs, e);
         end
         if (c == 803) begin
            start = 1'b1;
            x_in  = 8'd3;
            y_in  = 7'd4;
         end
         tick();
      end
      start = 1'b0;
      for (int c = 1; c <= 803; c++) begin
         e = model(c, 3, 4);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL b2b_second cyc %0d: got %h expected %h", c, obs, e);
         end
         tick();
      end
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      x_in   = 8'd0;
      y_in   = 7'd0;
      #1;
      test_reset();
      test_full_draw();
      test_transparency();
      test_clipping();
      test_mapping();
      test_start_busy();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
